alu_issue_scheduler: RTL

//  Shares the single combinational ALU between NUM_REQ reservation-station requesters.

---
 rtl/alu_issue_scheduler_pkg.sv | 44 ++++
 rtl/alu_issue_scheduler_rr_arbiter.sv | 31 +++
 rtl/alu_issue_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_issue_scheduler_pkg.sv
// Shared types for the ALU issue scheduler: ALU control word,
// operand word, op encoding, scheduler states and op latency lookup.
package alu_issue_scheduler_pkg;

  typedef logic [63:0] MemoryWord;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE,
    ALU_BLT, ALU_BGE, ALU_MUL, ALU_MULH,
    ALU_MULHU, ALU_MULW, ALU_DIV, ALU_DIVU,
    ALU_REM, ALU_REMU, ALU_DIVW, ALU_DIVUW,
    ALU_REMW, ALU_REMUW
  } aluop_e;

  typedef struct packed {
    aluop_e aluop;
    logic   imm_sel;
  } control_bits;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } sched_state_e;

  function automatic int unsigned alu_op_latency(
    aluop_e      op,
    int unsigned mul_lat,
    int unsigned div_lat
  );
    unique case (op)
      ALU_MUL, ALU_MULH,
      ALU_MULHU, ALU_MULW: return mul_lat;
      ALU_DIV, ALU_DIVU,
      ALU_REM, ALU_REMU,
      ALU_DIVW, ALU_DIVUW,
      ALU_REMW, ALU_REMUW: return div_lat;
      default:             return 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Shares one combinational ALU among reservation stations and
// broadcasts the tagged result on the CDB with valid/ready.
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  control_bits        req_ctrl [NUM_REQ],
  input  MemoryWord          req_srcA [NUM_REQ],
  input  MemoryWord          req_srcB [NUM_REQ],
  input  logic [TAG_W-1:0]   req_tag  [NUM_REQ],
  output control_bits        alu_ctrl,
  output MemoryWord          alu_srcA,
  output MemoryWord          alu_srcB,
  input  MemoryWord          alu_result,
  input  logic               alu_zero,
  output logic               cdb_valid,
  input  logic               cdb_ready,
  output logic [TAG_W-1:0]   cdb_tag,
  output MemoryWord          cdb_result,
  output logic               cdb_zero,
  output logic               busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e      state, state_n;
  logic [IW-1:0]     rr_ptr, rr_ptr_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              can_grant;
  logic              take;
  int unsigned       win_lat;
  logic              held;
  MemoryWord         res_q;
  logic              zero_q;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // A grant can ride on the same cycle as a CDB handshake.
  assign can_grant = !reset && !flush &&
    ((state == IDLE) || ((state == DONE) && cdb_ready));
  assign take      = can_grant && gnt_any;
  assign req_ready = take ? gnt : '0;
  assign win_lat   = alu_op_latency(
    req_ctrl[gnt_idx].aluop,
    MUL_LAT, DIV_LAT);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rr_ptr_n = rr_ptr;
    unique case (state)
      IDLE: state_n = IDLE;
      EXEC: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = DONE;
      end
      DONE: if (cdb_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (take) begin
      cnt_n    = CW'(win_lat - 1);
      rr_ptr_n = (gnt_idx == IW'(NUM_REQ - 1)) ?
        '0 : gnt_idx + IW'(1);
      state_n  = (win_lat > 1) ? EXEC : DONE;
    end
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      alu_ctrl <= '0;
      alu_srcA <= '0;
      alu_srcB <= '0;
      cdb_tag  <= '0;
      held     <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      cnt    <= cnt_n;
      if (take) begin
        alu_ctrl <= req_ctrl[gnt_idx];
        alu_srcA <= req_srcA[gnt_idx];
        alu_srcB <= req_srcB[gnt_idx];
        cdb_tag  <= req_tag[gnt_idx];
      end
      // Result is taken straight from the ALU on the first DONE
      // cycle and held in res_q while the CDB stalls.
      if ((state == DONE) && !held) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
      held <= (state == DONE) && (state_n == DONE) && !take;
    end
  end

  assign cdb_valid  = (state == DONE);
  assign cdb_result = held ? res_q : alu_result;
  assign cdb_zero   = held ? zero_q : alu_zero;
  assign busy       = (state != IDLE);

endmodule
